// File: rtl/conv2d_ctrl.sv
// conv2d_ctrl: per-channel weight fetch / load / plane sequencing for a conv core; optional watchdog via CONV2D_CTRL_WATCHDOG_EN
//   ports: clk, rst (async, active-high); cfg_valid/cfg_ready/cfg_width/cfg_length/cfg_nch job request;
//   wt_req/wt_ch/wt_valid/wt_data weight fetch; param_ena/param_weight/param_width/param_length core load;
//   core_start/core_busy plane handshake; ch_idx/first_ch channel; busy/done/err status
module conv2d_ctrl #(
  parameter int C_WIDTH  = 9,
  parameter int C_LENGTH = 18,
  parameter int KS       = 3,
  parameter int C_CH     = 8,
  parameter int WD_LIMIT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [C_WIDTH-1:0]     cfg_width,
  input  logic [C_LENGTH-1:0]    cfg_length,
  input  logic [C_CH-1:0]        cfg_nch,
  output logic                   wt_req,
  output logic [C_CH-1:0]        wt_ch,
  input  logic                   wt_valid,
  input  logic [KS*KS*32-1:0]    wt_data,
  output logic                   param_ena,
  output logic [KS*KS*32-1:0]    param_weight,
  output logic [C_WIDTH-1:0]     param_width,
  output logic [C_LENGTH-1:0]    param_length,
  output logic                   core_start,
  input  logic                   core_busy,
  output logic [C_CH-1:0]        ch_idx,
  output logic                   first_ch,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, WAIT_HI, WAIT_LO, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [C_WIDTH-1:0] width_q, width_d, param_width_q, param_width_d;
  logic [C_LENGTH-1:0] length_q, length_d, param_length_q, param_length_d;
  logic [C_CH-1:0] last_q, last_d, ch_q, ch_d;
  logic [KS*KS*32-1:0] param_weight_q, param_weight_d;
  logic wd_hit;
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    length_d = length_q;
    last_d = last_q;
    ch_d = ch_q;
    param_weight_d = param_weight_q;
    param_width_d = param_width_q;
    param_length_d = param_length_q;
    case (state_q)
      IDLE: if (cfg_valid) begin
        width_d = cfg_width;
        length_d = cfg_length;
        last_d = (cfg_nch == '0) ? '0 : cfg_nch - C_CH'(1);
        ch_d = '0;
        state_d = FETCH;
      end
      FETCH: if (wt_valid) begin
        param_weight_d = wt_data;
        param_width_d = width_q;
        param_length_d = length_q;
        state_d = LOAD;
      end
      LOAD: state_d = START;
      START: state_d = WAIT_HI;
      WAIT_HI: state_d = core_busy ? WAIT_LO : (wd_hit ? FIN : WAIT_HI);
      WAIT_LO: state_d = !core_busy ? NEXT : (wd_hit ? FIN : WAIT_LO);
      NEXT: begin
        state_d = (ch_q == last_q) ? FIN : FETCH;
        ch_d = (ch_q == last_q) ? ch_q : ch_q + C_CH'(1);
      end
      FIN: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      width_q <= '0;
      length_q <= '0;
      last_q <= '0;
      ch_q <= '0;
      param_weight_q <= '0;
      param_width_q <= '0;
      param_length_q <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      length_q <= length_d;
      last_q <= last_d;
      ch_q <= ch_d;
      param_weight_q <= param_weight_d;
      param_width_q <= param_width_d;
      param_length_q <= param_length_d;
    end
  end
`ifdef CONV2D_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d, in_wait;
  assign in_wait = state_q == WAIT_HI || state_q == WAIT_LO;
  assign wd_hit = in_wait && wd_q == WD_W'(WD_LIMIT - 1);
  // restarts from zero whenever a wait state is (re)entered
  assign wd_d = (in_wait && state_d == state_q) ? wd_q + WD_W'(1) : '0;
  assign err_d = err_q | wd_hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic wd_unused;
  assign wd_unused = |WD_LIMIT;
  assign wd_hit = 1'b0;
  assign err = 1'b0;
`endif
  assign cfg_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign wt_req = state_q == FETCH;
  assign wt_ch = ch_q;
  assign param_ena = state_q == LOAD;
  assign core_start = state_q == START;
  assign done = state_q == FIN;
  assign ch_idx = ch_q;
  assign first_ch = ch_q == '0;
  assign param_weight = param_weight_q;
  assign param_width = param_width_q;
  assign param_length = param_length_q;
endmodule

// File: tb/tb_conv2d_ctrl.sv
// tb_conv2d_ctrl: directed self-checking bench for conv2d_ctrl
module tb_conv2d_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [8:0] cfg_width = '0;
  logic [17:0] cfg_length = '0;
  logic [7:0] cfg_nch = '0;
  logic wt_req, wt_valid = 1'b0;
  logic [7:0] wt_ch, ch_idx;
  logic [287:0] wt_data = '0, param_weight;
  logic param_ena, core_start, core_busy = 1'b0, first_ch, busy, done, err;
  logic [8:0] param_width;
  logic [17:0] param_length;
  int n_chk = 0, n_fail = 0, n_ena = 0, n_start = 0, n_done = 0;
  logic [287:0] w0, w1, w2, w3, wx;

  conv2d_ctrl #(.WD_LIMIT(100)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_width(cfg_width), .cfg_length(cfg_length), .cfg_nch(cfg_nch),
    .wt_req(wt_req), .wt_ch(wt_ch), .wt_valid(wt_valid), .wt_data(wt_data),
    .param_ena(param_ena), .param_weight(param_weight), .param_width(param_width),
    .param_length(param_length), .core_start(core_start), .core_busy(core_busy),
    .ch_idx(ch_idx), .first_ch(first_ch), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    n_ena <= n_ena + int'(param_ena);
    n_start <= n_start + int'(core_start);
    n_done <= n_done + int'(done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FETCH entered; wt_valid 2 cycles later, core_busy high for hi cycles after core_start; ends in NEXT
  task automatic plane(input logic [7:0] ch, input logic [287:0] w, input logic [8:0] ew,
                       input logic [17:0] el, input int hi);
    chk("wt_req", 288'(wt_req), 288'(1));
    chk("wt_ch", 288'(wt_ch), 288'(ch));
    chk("first_ch", 288'(first_ch), 288'(ch == 8'd0));
    tick();
    tick();
    wt_valid = 1'b1;
    wt_data = w;
    tick();
    wt_valid = 1'b0;
    wt_data = '0;
    chk("param_ena", 288'(param_ena), 288'(1));
    chk("param_weight", param_weight, w);
    chk("param_width", 288'(param_width), 288'(ew));
    chk("param_length", 288'(param_length), 288'(el));
    tick();
    chk("core_start", 288'(core_start), 288'(1));
    tick();
    chk("core_start_pulse", 288'(core_start), 288'(0));
    core_busy = 1'b1;
    repeat (hi) tick();
    core_busy = 1'b0;
    tick();
    chk("next_busy", 288'(busy), 288'(1));
    chk("next_no_done", 288'(done), 288'(0));
  endtask

  initial begin
    w0 = {9{32'hA0A0_0001}};
    w1 = {9{32'hB1B1_0002}};
    w2 = {9{32'hC2C2_0003}};
    w3 = {9{32'hD3D3_0004}};
    wx = {9{32'hDEAD_BEEF}};
    tick();
    tick();
    chk("rst_ready", 288'(cfg_ready), 288'(1));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_done", 288'(done), 288'(0));
    chk("rst_err", 288'(err), 288'(0));
    chk("rst_wt_req", 288'(wt_req), 288'(0));
    chk("rst_ch_idx", 288'(ch_idx), 288'(0));
    chk("rst_param_weight", param_weight, '0);
    chk("rst_param_ena", 288'(param_ena), 288'(0));
    rst = 1'b0;
    tick();
    // job 1: width 8, length 64, 3 channels
    cfg_width = 9'd8;
    cfg_length = 18'd64;
    cfg_nch = 8'd3;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("j1_busy", 288'(busy), 288'(1));
    chk("j1_ready", 288'(cfg_ready), 288'(0));
    plane(8'd0, w0, 9'd8, 18'd64, 64);
    tick();
    plane(8'd1, w1, 9'd8, 18'd64, 64);
    tick();
    plane(8'd2, w2, 9'd8, 18'd64, 64);
    tick();
    chk("j1_done", 288'(done), 288'(1));
    chk("j1_last_ch", 288'(ch_idx), 288'(2));
    tick();
    chk("j1_done_pulse", 288'(done), 288'(0));
    chk("j1_idle_busy", 288'(busy), 288'(0));
    chk("j1_n_ena", 288'(n_ena), 288'(3));
    chk("j1_n_start", 288'(n_start), 288'(3));
    chk("j1_n_done", 288'(n_done), 288'(1));
    chk("j1_hold_weight", param_weight, w2);
    // wt_valid in IDLE alongside cfg is ignored; nch=0 runs one plane; cfg_valid held through job
    cfg_width = 9'd16;
    cfg_length = 18'd256;
    cfg_nch = 8'd0;
    cfg_valid = 1'b1;
    wt_valid = 1'b1;
    wt_data = wx;
    tick();
    wt_valid = 1'b0;
    wt_data = '0;
    chk("j2_ignore_wt", param_weight, w2);
    chk("j2_hold_width", 288'(param_width), 288'(8));
    plane(8'd0, w3, 9'd16, 18'd256, 5);
    chk("j2_ready_busy", 288'(cfg_ready), 288'(0));
    tick();
    chk("j2_done", 288'(done), 288'(1));
    tick();
    chk("j2_ready", 288'(cfg_ready), 288'(1));
    chk("j2_n_start", 288'(n_start), 288'(4));
    chk("j2_n_done", 288'(n_done), 288'(2));
    // job 3 accepted from the still-held cfg; spurious core_busy during FETCH
    tick();
    cfg_valid = 1'b0;
    chk("j3_busy", 288'(busy), 288'(1));
    core_busy = 1'b1;
    tick();
    tick();
    core_busy = 1'b0;
    chk("j3_still_fetch", 288'(wt_req), 288'(1));
    plane(8'd0, w1, 9'd16, 18'd256, 7);
    tick();
    chk("j3_done", 288'(done), 288'(1));
    chk("j3_n_start", 288'(n_start), 288'(5));
    tick();
    // job 4: abort with rst during WAIT_LO of channel 1
    cfg_width = 9'd4;
    cfg_length = 18'd16;
    cfg_nch = 8'd3;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    plane(8'd0, w0, 9'd4, 18'd16, 3);
    tick();
    chk("j4_ch1", 288'(ch_idx), 288'(1));
    tick();
    tick();
    wt_valid = 1'b1;
    wt_data = w2;
    tick();
    wt_valid = 1'b0;
    tick();
    tick();
    core_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 288'(busy), 288'(0));
    chk("abort_ready", 288'(cfg_ready), 288'(1));
    chk("abort_ch_idx", 288'(ch_idx), 288'(0));
    chk("abort_weight", param_weight, '0);
    chk("abort_length", 288'(param_length), 288'(0));
    chk("abort_done", 288'(done), 288'(0));
    core_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_n_done", 288'(n_done), 288'(3));
    // job 5: core_busy never rises
    cfg_nch = 8'd1;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("j5_accept", 288'(wt_req), 288'(1));
    wt_valid = 1'b1;
    wt_data = w3;
    tick();
    wt_valid = 1'b0;
    tick();
    tick();
`ifdef CONV2D_CTRL_WATCHDOG_EN
    repeat (99) tick();
    chk("wd_no_early_done", 288'(done), 288'(0));
    chk("wd_no_early_err", 288'(err), 288'(0));
    tick();
    chk("wd_done", 288'(done), 288'(1));
    chk("wd_err", 288'(err), 288'(1));
    tick();
    chk("wd_idle", 288'(busy), 288'(0));
    chk("wd_err_sticky", 288'(err), 288'(1));
`else
    repeat (200) tick();
    chk("nowd_busy", 288'(busy), 288'(1));
    chk("nowd_err", 288'(err), 288'(0));
    chk("nowd_done", 288'(n_done), 288'(3));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
